// File: rtl/aes_shift_rows_buf.sv
// Column-serial AES ShiftRows stage: a ping-pong pair of 4-column banks,
// one filling from in_col while the other drains permuted columns to MixColumns.
module aes_shift_rows_buf #(
    parameter bit INV = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_col,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_col,
    output logic [1:0]  out_idx,
    output logic        out_last
);

    logic [31:0] r_bank [2][4];
    logic        r_wr_bank;
    logic        r_rd_bank;
    logic [1:0]  r_wr_cnt;
    logic [1:0]  r_rd_cnt;
    logic [1:0]  r_full;

    logic        w_wr_fire;
    logic        w_rd_fire;
    logic [1:0]  w_full_nxt;
    logic [1:0]  w_src;
    logic [31:0] w_perm;

    assign in_ready  = ~r_full[r_wr_bank];
    assign out_valid = r_full[r_rd_bank];
    assign out_idx   = r_rd_cnt;
    assign out_last  = out_valid && (r_rd_cnt == 2'd3);
    assign out_col   = out_valid ? w_perm : '0;

    assign w_wr_fire = in_valid && in_ready;
    assign w_rd_fire = out_valid && out_ready;

    // Write completion and read completion always hit different banks,
    // so both updates can be applied to the same next-state vector.
    always_comb begin
        w_full_nxt = r_full;
        if (w_wr_fire && (r_wr_cnt == 2'd3)) begin
            w_full_nxt[r_wr_bank] = 1'b1;
        end
        if (w_rd_fire && (r_rd_cnt == 2'd3)) begin
            w_full_nxt[r_rd_bank] = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else if (flush) begin
            r_full    <= '0;
            r_wr_bank <= 1'b0;
            r_rd_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_rd_cnt  <= '0;
        end else begin
            r_full <= w_full_nxt;
            if (w_wr_fire) begin
                r_wr_cnt <= r_wr_cnt + 2'd1;
                if (r_wr_cnt == 2'd3) begin
                    r_wr_bank <= ~r_wr_bank;
                end
            end
            if (w_rd_fire) begin
                r_rd_cnt <= r_rd_cnt + 2'd1;
                if (r_rd_cnt == 2'd3) begin
                    r_rd_bank <= ~r_rd_bank;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            r_bank[r_wr_bank][r_wr_cnt] <= in_col;
        end
    end

    // Row r of output column c comes from column c+r (forward) or c-r (inverse), mod 4.
    always_comb begin
        w_perm = '0;
        w_src  = '0;
        for (int unsigned r = 0; r < 4; r++) begin
            w_src = INV ? (r_rd_cnt - 2'(r)) : (r_rd_cnt + 2'(r));
            w_perm[31-8*r -: 8] = r_bank[r_rd_bank][w_src][31-8*r -: 8];
        end
    end

endmodule

// File: doc/aes_shift_rows_buf.md
Name: aes_shift_rows_buf

Overview:
Column-serial ShiftRows stage that sits directly upstream of the MixColumns column multiplier. It accepts one 32-bit AES state column per handshake and collects four columns into a 128-bit state. It then emits the four ShiftRows-permuted columns one per handshake, ready to feed the MixColumns input. A ping-pong (two-bank) buffer lets one state fill while the other drains, sustaining 1 column/cycle.

Parameters:
INV, 0, 0 = forward ShiftRows (encrypt); 1 = InvShiftRows (decrypt)

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous clear of all buffer state; takes priority over handshakes
in_valid  input  1  in_col is valid
in_ready  output  1  stage can accept a column this cycle
in_col  input  32  state column; [31:24]=row0, [23:16]=row1, [15:8]=row2, [7:0]=row3
out_valid  output  1  out_col is valid
out_ready  input  1  downstream accepts out_col this cycle
out_col  output  32  permuted column, same byte/row ordering as in_col
out_idx  output  2  column index c (0..3) of out_col
out_last  output  1  high when out_idx==3 and out_valid

Behaviour:
- Clock/reset: one clock, clk. Reset rst_n is asynchronous, active-low, with synchronous deassertion handled externally.
- Storage: bank[0..1][0..3] of 32 bits. wr_bank, wr_cnt[1:0], rd_bank, rd_cnt[1:0], full[1:0].
- Reset (rst_n=0, asynchronous):
  - full=2'b00, wr_bank=0, wr_cnt=0, rd_bank=0, rd_cnt=0.
  - Outputs: in_ready=1, out_valid=0, out_idx=0, out_last=0.
  - Bank contents are don't-care, but out_col must read 32'h0 while out_valid=0. Gate out_col with out_valid.
- in_ready = !full[wr_bank]. Purely registered; no combinational path from out_ready.
- Write (in_valid && in_ready):
  - bank[wr_bank][wr_cnt] <= in_col; wr_cnt increments.
  - When wr_cnt==3: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- out_valid = full[rd_bank]. out_idx = rd_cnt. out_last = out_valid && rd_cnt==3.
- out_col byte mapping, with c=rd_cnt and B=bank[rd_bank]:
  - INV=0: row r byte taken from B[(c+r) mod 4] row r.
  - INV=1: row r byte taken from B[(c-r) mod 4] row r.
  - Row 0 is always B[c] row 0.
- Read (out_valid && out_ready):
  - rd_cnt increments.
  - When rd_cnt==3: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
- Latency: the first out column is valid on the cycle after the 4th input column is accepted. No later.
- Throughput: with out_ready held high and in_valid continuous, one column in and one out every cycle in steady state, with no bubbles.
- Simultaneous write-completion and read-completion in the same cycle:
  - They always target different banks, since a write requires !full[wr_bank].
  - Both updates take effect, so full can go 01→10 in one cycle.
- Both banks full: in_ready=0 until the draining bank's last column is accepted. in_ready rises the cycle after that acceptance.
- Backpressure: while out_valid && !out_ready, out_col, out_idx and out_last hold stable.
- Output stability: out_valid, once high, stays high until accepted. No withdrawal except on flush or reset.
- flush=1: same effect as reset on the next edge. Any in-flight partial input state (wr_cnt≠0) is discarded.
- Reset mid-operation: all partial and complete states are discarded. No output is produced for them after release.
- No arithmetic; pure byte permutation. Indices are 2-bit and wrap mod 4 naturally.

Test Plan:
- FIPS-197 round-1 forward, INV=0:
  - Stimulus: in_col d42711ae, e0bf98f1, b8b45de5, 1e415230 with out_ready=1.
  - Required: out_col d4bf5d30, e0b452ae, b84111f1, 1e2798e5 with out_idx 0..3 and out_last on the 4th.
  - Required: first out_valid exactly 1 cycle after the 4th input.
- Inverse, INV=1:
  - Stimulus: d4bf5d30, e0b452ae, b84111f1, 1e2798e5.
  - Required: out_col d42711ae, e0bf98f1, b8b45de5, 1e415230.
- Back-to-back streaming:
  - Stimulus: 3 states (12 columns, pattern 00010203+k*04040404), out_ready=1 throughout.
  - Required: in_ready stays 1, and outputs are contiguous 12 cycles starting cycle 5.
  - Required: state 0 col0 = 00050a0f.
- Backpressure:
  - Stimulus: out_ready=0 while feeding 8 columns, then 9th offered.
  - Required: full=11, in_ready=0 after the 8th column, and the 9th is not accepted.
  - Required: out_col holds d4bf5d30. After out_ready=1 for 4 cycles, in_ready returns to 1.
- Flush / reset mid-fill:
  - Stimulus: after 2 columns, pulse flush (then repeat with rst_n low).
  - Required: out_valid stays 0; a fresh 4-column state then emits the correct permutation with out_idx starting at 0.
- Simultaneous completion:
  - Stimulus: 4th write of bank 1 in the same cycle as the 4th read of bank 0.
  - Required: next cycle full=10, rd_bank=1, out_valid=1, out_idx=0.
